music_mixer: RTL and testbench
==============================

# music_mixer

Downstream stage of the YM music player: takes the player's 10-bit unsigned PSG output plus a 10-bit unsigned sound-effect stream and produces signed 16-bit stereo samples for the HDMI/analog audio path. Removes the PSG DC offset and applies a CPU-programmable 8-bit volume per channel, with frame-paced fades. Also applies sound-effect panning, saturating mix and mute. Sits between the music/sfx generators and the top-level `AUDIO_L/AUDIO_R`, and is controlled by the CPU through a 4-byte register window.

## Interface
- `FADE_CNT_W`, default 8: width of the frames-per-step counter.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ce_2` in 1: sample strobe, the same enable that clocks the PSG.
- `vblank` in 1: video vertical blank; the rising edge paces fades.
- `addr` in 2: register select.
- `data_in` in 8: register write data.
- `write` in 1: one-cycle register write strobe.
- `music_in` in 10: unsigned PSG sample, 0..1023.
- `sfx_in` in 10: unsigned sound-effect sample, 0..1023.
- `audio_l` out 16: signed left sample.
- `audio_r` out 16: signed right sample.
- `audio_valid` out 1: one-cycle pulse when `audio_l`/`audio_r` update.
- `fade_busy` out 1: high while either current volume differs from its target.

## Operation
- Registers: 0 = music volume target; 1 = sfx volume target; 2 = fade rate in frames per step (0 = immediate); 3 = control.
  - Control bit0 = mute.
  - Control bits[2:1] = sfx pan: 00 centre, 01 left only, 10 right only, 11 centre.
  - Control bits[7:3] are ignored.
- Reset values:
  - Both targets and both current volumes 0xFF; rate 0; control 0; frame counter 0.
  - `audio_l` = `audio_r` = 0; `audio_valid` = 0; `fade_busy` = 0.
- Fade, per channel:
  - If rate = 0, current volume equals target on the cycle after a target write.
  - Otherwise the frame counter increments on each `vblank` rising edge (edge detected against the previous-cycle `vblank`). When it reaches rate, it clears, and each channel whose current ≠ target steps by exactly 1 toward its target.
  - A write to register 2 clears the frame counter.
- Write on the same cycle as a fade step: the step is computed against the old target, and the new target applies from the next step. A write to register 0/1 with rate ≠ 0 does not touch the current volume.
- Datapath, per `ce_2`:
  - s_m = `music_in` − 512 and s_s = `sfx_in` − 512, each 11-bit signed (range −512..511).
  - p_m = s_m × cur_m and p_s = s_s × cur_s, with the volume treated as unsigned 0..255, giving 19-bit signed products.
  - left = p_m + (pan allows left ? p_s : 0); right = p_m + (pan allows right ? p_s : 0). Sums are 20-bit signed.
  - Arithmetic shift right by 2, then saturate to [−32768, 32767].
  - Mute forces both outputs to 0 at the output stage; the pipeline keeps running.
- Volumes, pan and mute are sampled at stage 1, so a change affects only samples captured afterwards.

## Timing
- 3-stage pipeline, advancing every `clk`:
  - Stage 1 captures the inputs on `ce_2` and computes the offset removal.
  - Stage 2 multiplies.
  - Stage 3 sums, shifts, saturates and registers the outputs.
- `audio_valid` pulses exactly 3 cycles after the `ce_2` that captured the data. Outputs hold their value between pulses.
- Back-to-back `ce_2` strobes (every cycle) must produce `audio_valid` every cycle with no loss.
- `fade_busy` is registered: it reflects the state after each update, with 1-cycle latency.
- Reset mid-pipeline: all in-flight samples are discarded, no `audio_valid` is issued, and registers return to their reset values on the next edge.

## Structure
- Package `music_mixer_pkg` holds:
  - Register addresses `MIX_REG_MUSVOL`/`SFXVOL`/`RATE`/`CTRL`.
  - Pan encodings.
  - `DC_OFFSET` = 512, `OUT_MAX`/`OUT_MIN`, and the shift amount 2.
- Sub-module `volume_ramp`, instanced twice (music, sfx). Inputs: target, write strobe, shared step strobe, rate_is_zero. Outputs: current volume and busy.
- The frame counter and edge detector live in the top level and drive the shared step strobe.

## Test plan
- Reset, then `ce_2` with music = 1023, sfx = 512: `audio_valid` 3 cycles later; `audio_l` = `audio_r` = (511×255)>>2 = 32576.
- Music = 0, sfx = 0, pan = 00, volumes 0xFF: sum −261120 >> 2 = −65280 → both outputs saturate to −32768.
- Pan = 01, music = 512, sfx = 1023: `audio_l` = 32576 and `audio_r` = 0. Then set mute: the next `audio_valid` gives 0/0.
- Rate = 2, write music target 0xFC from 0xFF: `fade_busy` rises; the volume reaches 0xFE after 2 vblank edges and 0xFC after 6; `fade_busy` drops one cycle after the volume reaches 0xFC.
- A target write coincident with a fade step, and a rate write mid-count: the step uses the old target and the counter restarts from 0.
- `ce_2` every cycle for 16 cycles with a counting input, with `reset_n` low at cycle 8: no `audio_valid` after reset and outputs 0. Before reset, outputs match the model in order.

Source files
------------

// File: rtl/music_mixer_pkg.sv
// Purpose: shared constants and helpers for the music/sfx mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register map, pan encodings, DC offset, output clamp limits, shift.
package music_mixer_pkg;

  // CPU register window
  localparam logic [1:0] MIX_REG_MUSVOL = 2'd0;
  localparam logic [1:0] MIX_REG_SFXVOL = 2'd1;
  localparam logic [1:0] MIX_REG_RATE   = 2'd2;
  localparam logic [1:0] MIX_REG_CTRL   = 2'd3;

  // Control bits[2:1]: where the sound effect goes
  typedef enum logic [1:0] {
    PAN_CENTRE = 2'b00,
    PAN_LEFT   = 2'b01,
    PAN_RIGHT  = 2'b10,
    PAN_BOTH   = 2'b11
  } pan_e;

  localparam int DC_OFFSET = 512;
  localparam int OUT_MAX   = 32767;
  localparam int OUT_MIN   = -32768;
  localparam int OUT_SHIFT = 2;

  function automatic logic pan_left_en(input logic [1:0] pan);
    return pan != PAN_RIGHT;
  endfunction

  function automatic logic pan_right_en(input logic [1:0] pan);
    return pan != PAN_LEFT;
  endfunction

  // Clamp a shifted 20-bit mix into the signed 16-bit output range
  function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'(OUT_MAX)) return 16'(OUT_MAX);
    if (v < 20'(OUT_MIN)) return 16'(OUT_MIN);
    return v[15:0];
  endfunction

endpackage

// File: rtl/music_mixer_volume_ramp.sv
// Purpose: one channel's volume target and current volume, stepping by 1 per fade step.
// Latency: immediate load 1 cycle after a write when rate is zero; otherwise 1 step per strobe.
// Backpressure: none; writes and steps are accepted every cycle.
// Ports: target_in/target_wr load the target, step is the shared fade strobe,
//        rate_is_zero selects immediate load, cur_vol/busy report the channel state.
module volume_ramp (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] target_in,
  input  logic       target_wr,
  input  logic       step,
  input  logic       rate_is_zero,
  output logic [7:0] cur_vol,
  output logic       busy
);

  logic [7:0] target_q;

  // The step compares against target_q before this cycle's write lands, so a
  // write coinciding with a step only takes effect from the following step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      target_q <= 8'hFF;
      cur_vol  <= 8'hFF;
    end else begin
      if (target_wr) target_q <= target_in;
      if (target_wr && rate_is_zero) begin
        cur_vol <= target_in;
      end else if (step && (cur_vol != target_q)) begin
        cur_vol <= (cur_vol < target_q) ? cur_vol + 8'd1 : cur_vol - 8'd1;
      end
    end
  end

  assign busy = (cur_vol != target_q);

endmodule

// File: rtl/music_mixer.sv
// Purpose: DC-removal, per-channel volume with vblank-paced fades, sfx pan, saturating mix, mute.
// Latency: audio_valid on the third clk edge counting the edge that samples ce_2.
// Backpressure: none; the pipeline advances every clk and accepts ce_2 every cycle.
// Ports: clk/reset_n; ce_2 sample strobe; vblank fade pacing; addr/data_in/write CPU
//        register window; music_in/sfx_in unsigned samples; audio_l/audio_r/audio_valid
//        signed stereo out; fade_busy while any volume is still ramping.
module music_mixer
  import music_mixer_pkg::*;
#(
  parameter int FADE_CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_2,
  input  logic               vblank,
  input  logic [1:0]         addr,
  input  logic [7:0]         data_in,
  input  logic               write,
  input  logic [9:0]         music_in,
  input  logic [9:0]         sfx_in,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               audio_valid,
  output logic               fade_busy
);

  // Compare width wide enough for both rate and counter+1
  localparam int CMP_W = (FADE_CNT_W + 1 > 8) ? FADE_CNT_W + 1 : 8;

  // ---------------- register window ----------------
  logic       wr_mus, wr_sfx, wr_rate, wr_ctrl;
  logic [7:0] rate_q;
  logic       ctrl_mute;
  logic [1:0] ctrl_pan;

  assign wr_mus  = write && (addr == MIX_REG_MUSVOL);
  assign wr_sfx  = write && (addr == MIX_REG_SFXVOL);
  assign wr_rate = write && (addr == MIX_REG_RATE);
  assign wr_ctrl = write && (addr == MIX_REG_CTRL);

  // ---------------- fade pacing ----------------
  logic                  vblank_q;
  logic                  vblank_rise;
  logic [FADE_CNT_W-1:0] frame_cnt;
  logic [CMP_W-1:0]      cnt_inc, rate_ext;
  logic                  rate_is_zero;
  logic                  fade_step;

  assign vblank_rise  = vblank && !vblank_q;
  assign rate_is_zero = (rate_q == 8'd0);
  assign cnt_inc      = CMP_W'(frame_cnt) + CMP_W'(1);
  assign rate_ext     = CMP_W'(rate_q);
  // A rate write restarts the count, so it also suppresses a coincident step
  assign fade_step    = vblank_rise && !rate_is_zero && !wr_rate && (cnt_inc == rate_ext);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate_q    <= 8'd0;
      ctrl_mute <= 1'b0;
      ctrl_pan  <= 2'b00;
      vblank_q  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vblank_q <= vblank;
      if (wr_rate) rate_q <= data_in;
      if (wr_ctrl) begin
        ctrl_mute <= data_in[0];
        ctrl_pan  <= data_in[2:1];
      end
      if (wr_rate) begin
        frame_cnt <= '0;
      end else if (vblank_rise && !rate_is_zero) begin
        frame_cnt <= fade_step ? '0 : frame_cnt + 1'b1;
      end
    end
  end

  logic [7:0] cur_m, cur_s;
  logic       busy_m, busy_s;

  volume_ramp u_ramp_mus (
    .clk          (clk),
    .reset_n      (reset_n),
    .target_in    (data_in),
    .target_wr    (wr_mus),
    .step         (fade_step),
    .rate_is_zero (rate_is_zero),
    .cur_vol      (cur_m),
    .busy         (busy_m)
  );

  volume_ramp u_ramp_sfx (
    .clk          (clk),
    .reset_n      (reset_n),
    .target_in    (data_in),
    .target_wr    (wr_sfx),
    .step         (fade_step),
    .rate_is_zero (rate_is_zero),
    .cur_vol      (cur_s),
    .busy         (busy_s)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) fade_busy <= 1'b0;
    else          fade_busy <= busy_m || busy_s;
  end

  // ---------------- stage 1: capture, remove DC offset ----------------
  logic               s1_vld;
  logic signed [10:0] s1_m, s1_s;
  logic [7:0]         s1_vol_m, s1_vol_s;
  logic               s1_sel_l, s1_sel_r, s1_mute;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld   <= 1'b0;
      s1_m     <= '0;
      s1_s     <= '0;
      s1_vol_m <= '0;
      s1_vol_s <= '0;
      s1_sel_l <= 1'b0;
      s1_sel_r <= 1'b0;
      s1_mute  <= 1'b0;
    end else begin
      s1_vld <= ce_2;
      if (ce_2) begin
        s1_m     <= $signed({1'b0, music_in}) - 11'(DC_OFFSET);
        s1_s     <= $signed({1'b0, sfx_in}) - 11'(DC_OFFSET);
        s1_vol_m <= cur_m;
        s1_vol_s <= cur_s;
        s1_sel_l <= pan_left_en(ctrl_pan);
        s1_sel_r <= pan_right_en(ctrl_pan);
        s1_mute  <= ctrl_mute;
      end
    end
  end

  // ---------------- stage 2: scale by volume ----------------
  // Operands widened to the 19-bit product width; the volume is unsigned.
  logic signed [18:0] mul_m_a, mul_m_b, mul_s_a, mul_s_b;
  assign mul_m_a = {{8{s1_m[10]}}, s1_m};
  assign mul_m_b = {11'b0, s1_vol_m};
  assign mul_s_a = {{8{s1_s[10]}}, s1_s};
  assign mul_s_b = {11'b0, s1_vol_s};

  logic               s2_vld;
  logic signed [18:0] s2_pm, s2_ps;
  logic               s2_sel_l, s2_sel_r, s2_mute;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_vld   <= 1'b0;
      s2_pm    <= '0;
      s2_ps    <= '0;
      s2_sel_l <= 1'b0;
      s2_sel_r <= 1'b0;
      s2_mute  <= 1'b0;
    end else begin
      s2_vld   <= s1_vld;
      s2_pm    <= mul_m_a * mul_m_b;
      s2_ps    <= mul_s_a * mul_s_b;
      s2_sel_l <= s1_sel_l;
      s2_sel_r <= s1_sel_r;
      s2_mute  <= s1_mute;
    end
  end

  // ---------------- stage 3: mix, shift, saturate ----------------
  logic signed [19:0] sum_l, sum_r, shf_l, shf_r;
  assign sum_l = {s2_pm[18], s2_pm} + (s2_sel_l ? {s2_ps[18], s2_ps} : 20'd0);
  assign sum_r = {s2_pm[18], s2_pm} + (s2_sel_r ? {s2_ps[18], s2_ps} : 20'd0);
  assign shf_l = sum_l >>> OUT_SHIFT;
  assign shf_r = sum_r >>> OUT_SHIFT;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      audio_l     <= '0;
      audio_r     <= '0;
      audio_valid <= 1'b0;
    end else begin
      audio_valid <= s2_vld;
      if (s2_vld) begin
        audio_l <= s2_mute ? 16'sd0 : sat16(shf_l);
        audio_r <= s2_mute ? 16'sd0 : sat16(shf_r);
      end
    end
  end

endmodule

// File: tb/tb_music_mixer.sv
module tb_music_mixer;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ce_2 = 1'b0;
  logic               vblank = 1'b0;
  logic [1:0]         addr = 2'd0;
  logic [7:0]         data_in = 8'd0;
  logic               write = 1'b0;
  logic [9:0]         music_in = 10'd0;
  logic [9:0]         sfx_in = 10'd0;
  logic signed [15:0] audio_l, audio_r;
  logic               audio_valid, fade_busy;

  always #5 clk = ~clk;

  music_mixer #(.FADE_CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_2        (ce_2),
    .vblank      (vblank),
    .addr        (addr),
    .data_in     (data_in),
    .write       (write),
    .music_in    (music_in),
    .sfx_in      (sfx_in),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .audio_valid (audio_valid),
    .fade_busy   (fade_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the mixing rules
  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model(input int m, input int s, input int vm, input int vs,
                                input int c, output int l, output int r);
    int pm, ps, pan, sl, sr;
    pm  = (m - 512) * vm;
    ps  = (s - 512) * vs;
    pan = (c >> 1) & 3;
    sl  = pm + ((pan == 2) ? 0 : ps);
    sr  = pm + ((pan == 1) ? 0 : ps);
    l   = clamp16(sl >>> 2);
    r   = clamp16(sr >>> 2);
    if ((c & 1) != 0) begin
      l = 0;
      r = 0;
    end
  endfunction

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Single ce_2 strobe; lat counts edges until audio_valid (10 = timeout)
  task automatic capture(input logic [9:0] m, input logic [9:0] s,
                         output int l, output int r, output int lat);
    @(negedge clk);
    music_in = m; sfx_in = s; ce_2 = 1'b1;
    @(negedge clk);
    ce_2 = 1'b0;
    lat = 1;
    while (!audio_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    l = int'(audio_l);
    r = int'(audio_r);
  endtask

  task automatic vblank_pulse();
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
  endtask

  task automatic vol_check(input string name, input int v);
    int l, r, lat;
    capture(10'd1023, 10'd512, l, r, lat);
    check(name, l, (511 * v) >>> 2);
  endtask

  // Scoreboard for streaming phases
  int  exp_l_q[$];
  int  exp_r_q[$];
  bit  mon_en = 1'b0;
  int  n_seen = 0;

  always @(negedge clk) begin
    if (mon_en && audio_valid) begin
      n_seen++;
      if (exp_l_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_extra: audio_valid with no expected sample (l=%0d r=%0d)", audio_l, audio_r);
      end else begin
        check("stream_l", int'(audio_l), exp_l_q.pop_front());
        check("stream_r", int'(audio_r), exp_r_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [9:0] m;
    logic [9:0] s;
    logic [7:0] vm;
    logic [7:0] vs;
    logic [7:0] ctrl;
    int         el;
    int         er;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, r, lat, el, er, vm, vs, c, n0, n1;

    vecs[0]  = '{10'd1023, 10'd512,  8'hFF, 8'hFF, 8'h00,  32576,  32576};
    vecs[1]  = '{10'd0,    10'd0,    8'hFF, 8'hFF, 8'h00, -32768, -32768};
    vecs[2]  = '{10'd512,  10'd1023, 8'hFF, 8'hFF, 8'h02,  32576,      0};
    vecs[3]  = '{10'd512,  10'd1023, 8'hFF, 8'hFF, 8'h03,      0,      0};
    vecs[4]  = '{10'd512,  10'd0,    8'hFF, 8'hFF, 8'h04,      0, -32640};
    vecs[5]  = '{10'd1023, 10'd512,  8'h80, 8'hFF, 8'h00,  16352,  16352};
    vecs[6]  = '{10'd1023, 10'd1023, 8'hFF, 8'hFF, 8'h00,  32767,  32767};
    vecs[7]  = '{10'd0,    10'd768,  8'h00, 8'h10, 8'h00,   1024,   1024};
    vecs[8]  = '{10'd511,  10'd512,  8'hFF, 8'hFF, 8'h00,    -64,    -64};
    vecs[9]  = '{10'd512,  10'd0,    8'h00, 8'h01, 8'h06,   -128,   -128};
    vecs[10] = '{10'd1023, 10'd512,  8'hFF, 8'hFF, 8'hF8,  32576,  32576};
    vecs[11] = '{10'd0,    10'd1023, 8'hFF, 8'hFF, 8'h02,    -64, -32640};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_audio_l", int'(audio_l), 0);
    check("reset_audio_r", int'(audio_r), 0);
    check("reset_valid", int'(audio_valid), 0);
    check("reset_busy", int'(fade_busy), 0);

    // Reset volumes are 0xFF, no writes needed
    capture(10'd1023, 10'd512, l, r, lat);
    check("first_latency", lat, 3);
    check("first_l", l, 32576);
    check("first_r", r, 32576);

    // ---- table vectors ----
    for (int i = 0; i < 12; i++) begin
      reg_write(2'd0, vecs[i].vm);
      reg_write(2'd1, vecs[i].vs);
      reg_write(2'd3, vecs[i].ctrl);
      capture(vecs[i].m, vecs[i].s, l, r, lat);
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_l", i), l, vecs[i].el);
      check($sformatf("vec%0d_r", i), r, vecs[i].er);
    end
    @(negedge clk);
    check("hold_valid", int'(audio_valid), 0);
    check("hold_l", int'(audio_l), vecs[11].el);

    // ---- fade: rate 2, 0xFF -> 0xFC ----
    reg_write(2'd3, 8'h00);
    reg_write(2'd2, 8'd2);
    reg_write(2'd0, 8'hFC);
    @(negedge clk);
    check("fade_busy_rise", int'(fade_busy), 1);
    vblank_pulse();
    vol_check("fade_vol_1edge", 255);
    vblank_pulse();
    vol_check("fade_vol_2edge", 254);
    vblank_pulse();
    vblank_pulse();
    vol_check("fade_vol_4edge", 253);
    vblank_pulse();
    vblank_pulse();
    check("fade_busy_at_reach", int'(fade_busy), 1);
    @(negedge clk);
    check("fade_busy_drop", int'(fade_busy), 0);
    vol_check("fade_vol_6edge", 252);

    // Target write on the same cycle as a step: old target governs that step
    reg_write(2'd0, 8'hFA);
    vblank_pulse();
    @(negedge clk);
    vblank = 1'b1; addr = 2'd0; data_in = 8'hFF; write = 1'b1;
    @(negedge clk);
    vblank = 1'b0; write = 1'b0;
    vol_check("coincident_step_old_target", 251);
    vblank_pulse();
    vblank_pulse();
    vol_check("coincident_then_new_target", 252);

    // Rate write mid-count restarts the frame counter
    vblank_pulse();
    reg_write(2'd2, 8'd2);
    vblank_pulse();
    vol_check("rate_write_restart", 252);
    vblank_pulse();
    vol_check("rate_write_step", 253);

    // ---- randomized stream against the model ----
    reg_write(2'd2, 8'd0);
    reg_write(2'd0, 8'hFF);
    reg_write(2'd1, 8'hFF);
    reg_write(2'd3, 8'h00);
    vm = 255; vs = 255; c = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        int a;
        int d;
        a = $urandom_range(0, 2);
        if (a == 2) a = 3;
        d = $urandom_range(0, 255);
        ce_2 = 1'b0; addr = 2'(a); data_in = 8'(d); write = 1'b1;
        if (a == 0) vm = d;
        else if (a == 1) vs = d;
        else c = d;
      end else begin
        write = 1'b0;
        ce_2 = ($urandom_range(0, 3) != 0);
        music_in = 10'($urandom_range(0, 1023));
        sfx_in = 10'($urandom_range(0, 1023));
        if (ce_2) begin
          model(int'(music_in), int'(sfx_in), vm, vs, c, el, er);
          exp_l_q.push_back(el);
          exp_r_q.push_back(er);
        end
      end
    end
    @(negedge clk);
    ce_2 = 1'b0; write = 1'b0;
    repeat (6) @(negedge clk);
    check("rand_drain", exp_l_q.size(), 0);

    // ---- back-to-back stream with reset in the middle ----
    reg_write(2'd0, 8'hFF);
    reg_write(2'd1, 8'hFF);
    reg_write(2'd3, 8'h00);
    repeat (4) @(negedge clk);
    n0 = n_seen;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ce_2 = 1'b1;
      music_in = 10'(i * 64);
      sfx_in = 10'(1023 - i * 40);
      reset_n = (i < 8);
      if (i < 8) begin
        model(i * 64, 1023 - i * 40, 255, 255, 0, el, er);
        exp_l_q.push_back(el);
        exp_r_q.push_back(er);
      end
    end
    @(negedge clk);
    ce_2 = 1'b0;
    reset_n = 1'b1;
    check("midreset_valid_count", n_seen - n0, 6);
    exp_l_q.delete();
    exp_r_q.delete();
    n1 = n_seen;
    repeat (6) @(negedge clk);
    check("post_reset_no_valid", n_seen - n1, 0);
    check("post_reset_l", int'(audio_l), 0);
    check("post_reset_r", int'(audio_r), 0);
    check("post_reset_busy", int'(fade_busy), 0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
